// File: rtl/cut_sweep_pkg.sv
// Shared types and defaults for the CUT timing-sweep controller.
// The counter-width helper sizes the one cycle counter shared by every timed state.
package cut_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_WAIT_PS = 3'd2,
      ST_CLEAR   = 3'd3,
      ST_RUN     = 3'd4,
      ST_SETTLE  = 3'd5,
      ST_CHECK   = 3'd6,
      ST_DONE    = 3'd7
   } sweep_state_e;

   localparam int DEF_NUM_STEPS     = 56;
   localparam int DEF_STEP_W        = 6;
   localparam int DEF_TRIAL_CYCLES  = 1024;
   localparam int DEF_CLEAR_CYCLES  = 4;
   localparam int DEF_SETTLE_CYCLES = 4;
   localparam int DEF_PS_TIMEOUT    = 255;
   localparam int DEF_STOP_ON_FAIL  = 1;

   // Width that holds the largest terminal count of any timed state.
   function automatic int cnt_width(input int trial, input int clear,
                                    input int settle, input int ps_timeout);
      int m;
      m = trial;
      if (clear > m) m = clear;
      if (settle > m) m = settle;
      if (ps_timeout > m) m = ps_timeout;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the sticky CUT diff flag into normal_clk.
// Both flops carry ASYNC_REG so placement keeps them adjacent.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic meta;
   (* ASYNC_REG = "TRUE" *) logic sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
      end else begin
         meta <= d;
         sync <= meta;
      end
   end

   assign q = sync;

endmodule

// File: rtl/cut_sweep_ctrl.sv
// Sequencer sweeping the fast-clock phase across one CUT: per step it clears the
// diff flag, toggles the CUT input, settles, samples diff, then phase-shifts the MMCM.
module cut_sweep_ctrl
   import cut_sweep_pkg::*;
#(
   parameter int NUM_STEPS     = DEF_NUM_STEPS,
   parameter int STEP_W        = DEF_STEP_W,
   parameter int TRIAL_CYCLES  = DEF_TRIAL_CYCLES,
   parameter int CLEAR_CYCLES  = DEF_CLEAR_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int PS_TIMEOUT    = DEF_PS_TIMEOUT,
   parameter int STOP_ON_FAIL  = DEF_STOP_ON_FAIL
) (
   input  logic              normal_clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              ps_done,
   input  logic              diff_in,
   output logic              data_out,
   output logic              clear_diff,
   output logic              ps_en,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              fail_found,
   output logic [STEP_W-1:0] fail_step,
   output logic [STEP_W:0]   pass_count,
   output logic [STEP_W-1:0] cur_step,
   output sweep_state_e      state_dbg
);

   localparam int CNT_W = cnt_width(TRIAL_CYCLES, CLEAR_CYCLES, SETTLE_CYCLES, PS_TIMEOUT);

   localparam logic [CNT_W-1:0]  TRIAL_LAST  = CNT_W'(TRIAL_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  PS_LAST     = CNT_W'(PS_TIMEOUT - 1);
   localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(NUM_STEPS - 1);

   sweep_state_e     state;
   logic [CNT_W-1:0] cnt;
   logic             diff_sync;

   sync_2ff u_diff_sync (
      .clk   (normal_clk),
      .reset (reset),
      .d     (diff_in),
      .q     (diff_sync)
   );

   // Phase-shift handshake: ps_en is a one-cycle request raised on leaving CHECK;
   // ps_done is a one-cycle completion honoured only in WAIT_PS, at most one request
   // outstanding. No ps_done within PS_TIMEOUT cycles of WAIT_PS ends the sweep with error.
   always_ff @(posedge normal_clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         data_out   <= 1'b0;
         clear_diff <= 1'b0;
         ps_en      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         fail_found <= 1'b0;
         fail_step  <= '0;
         pass_count <= '0;
         cur_step   <= '0;
      end else if (abort) begin
         state      <= ST_DONE;
         cnt        <= '0;
         data_out   <= 1'b0;
         clear_diff <= 1'b0;
         ps_en      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b1;
      end else begin
         ps_en <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_CLEAR;
                  cnt        <= '0;
                  cur_step   <= '0;
                  error      <= 1'b0;
                  fail_found <= 1'b0;
                  fail_step  <= '0;
                  pass_count <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  clear_diff <= 1'b1;
                  data_out   <= 1'b0;
               end
            end

            ST_SHIFT: begin
               state <= ST_WAIT_PS;
               cnt   <= '0;
            end

            ST_WAIT_PS: begin
               if (ps_done) begin
                  state      <= ST_CLEAR;
                  cnt        <= '0;
                  clear_diff <= 1'b1;
               end else if (cnt == PS_LAST) begin
                  state <= ST_DONE;
                  cnt   <= '0;
                  error <= 1'b1;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_CLEAR: begin
               if (cnt == CLEAR_LAST) begin
                  state      <= ST_RUN;
                  cnt        <= '0;
                  clear_diff <= 1'b0;
                  data_out   <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            // Even trial length: the last RUN cycle already drives 0.
            ST_RUN: begin
               if (cnt == TRIAL_LAST) begin
                  state    <= ST_SETTLE;
                  cnt      <= '0;
                  data_out <= 1'b0;
               end else begin
                  cnt      <= cnt + 1'b1;
                  data_out <= ~data_out;
               end
            end

            ST_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state <= ST_CHECK;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_CHECK: begin
               if (diff_sync) begin
                  if (!fail_found) begin
                     fail_found <= 1'b1;
                     fail_step  <= cur_step;
                  end
               end else begin
                  pass_count <= pass_count + 1'b1;
               end
               if ((diff_sync && (STOP_ON_FAIL != 0)) || (cur_step == LAST_STEP)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state    <= ST_SHIFT;
                  cur_step <= cur_step + 1'b1;
                  ps_en    <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_cut_sweep_ctrl.sv
// Directed bench for cut_sweep_ctrl: two instances (stop-on-fail and full-sweep) share
// host stimulus; each has its own CUT model and MMCM phase-shift responder.
module tb_cut_sweep_ctrl;
   import cut_sweep_pkg::*;

   localparam int NS = 4;
   localparam int SW = 2;

   logic normal_clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;

   logic          ps_done_s, diff_s, data_out_s, clear_diff_s, ps_en_s, busy_s, done_s, error_s, fail_found_s;
   logic [SW-1:0] fail_step_s, cur_step_s;
   logic [SW:0]   pass_count_s;
   sweep_state_e  state_s;

   logic          ps_done_c, diff_c, data_out_c, clear_diff_c, ps_en_c, busy_c, done_c, error_c, fail_found_c;
   logic [SW-1:0] fail_step_c, cur_step_c;
   logic [SW:0]   pass_count_c;
   sweep_state_e  state_c;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int s_cyc = 0;
   int dcyc_s = -1;
   int dcyc_c = -1;
   int fail_phase = 99;
   bit ps_ack_on = 1'b1;

   always #5 normal_clk = ~normal_clk;

   cut_sweep_ctrl #(.NUM_STEPS(NS), .STEP_W(SW), .TRIAL_CYCLES(8), .CLEAR_CYCLES(4),
                    .SETTLE_CYCLES(4), .PS_TIMEOUT(16), .STOP_ON_FAIL(1)) dut_s (
      .normal_clk(normal_clk), .reset(reset), .start(start), .abort(abort),
      .ps_done(ps_done_s), .diff_in(diff_s), .data_out(data_out_s), .clear_diff(clear_diff_s),
      .ps_en(ps_en_s), .busy(busy_s), .done(done_s), .error(error_s), .fail_found(fail_found_s),
      .fail_step(fail_step_s), .pass_count(pass_count_s), .cur_step(cur_step_s), .state_dbg(state_s)
   );

   cut_sweep_ctrl #(.NUM_STEPS(NS), .STEP_W(SW), .TRIAL_CYCLES(8), .CLEAR_CYCLES(4),
                    .SETTLE_CYCLES(4), .PS_TIMEOUT(16), .STOP_ON_FAIL(0)) dut_c (
      .normal_clk(normal_clk), .reset(reset), .start(start), .abort(abort),
      .ps_done(ps_done_c), .diff_in(diff_c), .data_out(data_out_c), .clear_diff(clear_diff_c),
      .ps_en(ps_en_c), .busy(busy_c), .done(done_c), .error(error_c), .fail_found(fail_found_c),
      .fail_step(fail_step_c), .pass_count(pass_count_c), .cur_step(cur_step_c), .state_dbg(state_c)
   );

   // MMCM answers ps_en after 5 cycles; CUT diff goes sticky once the phase reaches fail_phase.
   logic [4:0] pipe_s = '0;
   logic [4:0] pipe_c = '0;
   int phase_s = 0, phase_c = 0, nps_s = 0, nps_c = 0;
   logic dreg_s = 1'b0, dreg_c = 1'b0;

   assign ps_done_s = pipe_s[4];
   assign ps_done_c = pipe_c[4];
   assign diff_s = dreg_s;
   assign diff_c = dreg_c;

   always @(posedge normal_clk) begin
      cyc    <= cyc + 1;
      pipe_s <= {pipe_s[3:0], ps_en_s & ps_ack_on};
      pipe_c <= {pipe_c[3:0], ps_en_c & ps_ack_on};
      if (start) phase_s <= 0; else if (ps_done_s) phase_s <= phase_s + 1;
      if (start) phase_c <= 0; else if (ps_done_c) phase_c <= phase_c + 1;
      if (start) nps_s <= 0; else if (ps_en_s) nps_s <= nps_s + 1;
      if (start) nps_c <= 0; else if (ps_en_c) nps_c <= nps_c + 1;
      if (clear_diff_s) dreg_s <= 1'b0; else if (data_out_s && phase_s >= fail_phase) dreg_s <= 1'b1;
      if (clear_diff_c) dreg_c <= 1'b0; else if (data_out_c && phase_c >= fail_phase) dreg_c <= 1'b1;
   end

   task automatic tick();
      @(posedge normal_clk);
      #1;
   endtask

   task automatic pulse_start();
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic wait_done(input int budget);
      dcyc_s = -1;
      dcyc_c = -1;
      for (int i = 0; i < budget && (dcyc_s < 0 || dcyc_c < 0); i++) begin
         tick();
         if (dcyc_s < 0 && done_s) dcyc_s = cyc - s_cyc;
         if (dcyc_c < 0 && done_c) dcyc_c = cyc - s_cyc;
      end
      total++; if (dcyc_s < 0 || dcyc_c < 0) begin bad++; $display("FAIL wait_done: timed out, cycles s=%0d c=%0d", dcyc_s, dcyc_c); end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      total++; if ({busy_s, done_s, error_s, fail_found_s, data_out_s, clear_diff_s, ps_en_s} !== 7'b0) begin bad++; $display("FAIL reset_flags: got %b want 0", {busy_s, done_s, error_s, fail_found_s, data_out_s, clear_diff_s, ps_en_s}); end
      total++; if ({fail_step_s, pass_count_s, cur_step_s} !== '0) begin bad++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", fail_step_s, pass_count_s, cur_step_s); end
      reset = 1'b0;
      tick();
      total++; if (state_s !== ST_IDLE || state_c !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d/%0d want %0d", state_s, state_c, ST_IDLE); end
      total++; if (busy_c !== 1'b0 || done_c !== 1'b0) begin bad++; $display("FAIL reset_busy_done_c: got %b%b want 00", busy_c, done_c); end
   endtask

   task automatic test_full_pass();
      fail_phase = 99;
      ps_ack_on = 1'b1;
      pulse_start();
      total++; if (busy_s !== 1'b1 || done_s !== 1'b0) begin bad++; $display("FAIL start_busy: got busy=%b done=%b want 1/0", busy_s, done_s); end
      total++; if (state_s !== ST_CLEAR || clear_diff_s !== 1'b1 || data_out_s !== 1'b0) begin bad++; $display("FAIL clear_entry: got st=%0d clr=%b d=%b want %0d/1/0", state_s, clear_diff_s, data_out_s, ST_CLEAR); end
      repeat (4) tick();
      total++; if (state_s !== ST_RUN || data_out_s !== 1'b1 || clear_diff_s !== 1'b0) begin bad++; $display("FAIL run_entry: got st=%0d d=%b clr=%b want %0d/1/0", state_s, data_out_s, clear_diff_s, ST_RUN); end
      tick();
      total++; if (data_out_s !== 1'b0) begin bad++; $display("FAIL run_toggle: got %b want 0", data_out_s); end
      wait_done(200);
      total++; if (dcyc_s !== 86 || dcyc_c !== 86) begin bad++; $display("FAIL pass_latency: got %0d/%0d want 86", dcyc_s, dcyc_c); end
      total++; if (pass_count_s !== 3'd4 || pass_count_c !== 3'd4) begin bad++; $display("FAIL pass_count: got %0d/%0d want 4", pass_count_s, pass_count_c); end
      total++; if (fail_found_s !== 1'b0 || error_s !== 1'b0 || busy_s !== 1'b0) begin bad++; $display("FAIL pass_flags: got ff=%b err=%b busy=%b want 0/0/0", fail_found_s, error_s, busy_s); end
      total++; if (nps_s !== 3 || cur_step_s !== 2'd3) begin bad++; $display("FAIL pass_steps: got ps_en=%0d step=%0d want 3/3", nps_s, cur_step_s); end
   endtask

   task automatic test_fail_stop_and_sweep();
      fail_phase = 2;
      pulse_start();
      wait_done(200);
      total++; if (dcyc_s !== 63 || dcyc_c !== 86) begin bad++; $display("FAIL fail_latency: got %0d/%0d want 63/86", dcyc_s, dcyc_c); end
      total++; if (fail_found_s !== 1'b1 || fail_step_s !== 2'd2) begin bad++; $display("FAIL fail_step_stop: got ff=%b step=%0d want 1/2", fail_found_s, fail_step_s); end
      total++; if (fail_found_c !== 1'b1 || fail_step_c !== 2'd2) begin bad++; $display("FAIL fail_step_sweep: got ff=%b step=%0d want 1/2", fail_found_c, fail_step_c); end
      total++; if (pass_count_s !== 3'd2 || pass_count_c !== 3'd2) begin bad++; $display("FAIL fail_pass_count: got %0d/%0d want 2/2", pass_count_s, pass_count_c); end
      total++; if (cur_step_s !== 2'd2 || cur_step_c !== 2'd3) begin bad++; $display("FAIL fail_cur_step: got %0d/%0d want 2/3", cur_step_s, cur_step_c); end
      total++; if (nps_s !== 2 || nps_c !== 3) begin bad++; $display("FAIL fail_ps_pulses: got %0d/%0d want 2/3", nps_s, nps_c); end
      fail_phase = 99;
   endtask

   task automatic test_ps_timeout();
      ps_ack_on = 1'b0;
      pulse_start();
      wait_done(200);
      total++; if (dcyc_s !== 34 || dcyc_c !== 34) begin bad++; $display("FAIL timeout_latency: got %0d/%0d want 34", dcyc_s, dcyc_c); end
      total++; if (error_s !== 1'b1 || error_c !== 1'b1 || busy_s !== 1'b0) begin bad++; $display("FAIL timeout_error: got err=%b/%b busy=%b want 1/1/0", error_s, error_c, busy_s); end
      total++; if (nps_s !== 1 || pass_count_s !== 3'd1 || cur_step_s !== 2'd1) begin bad++; $display("FAIL timeout_state: got ps_en=%0d pass=%0d step=%0d want 1/1/1", nps_s, pass_count_s, cur_step_s); end
      ps_ack_on = 1'b1;
   endtask

   task automatic test_abort();
      pulse_start();
      total++; if (error_s !== 1'b0 || done_s !== 1'b0) begin bad++; $display("FAIL restart_clears: got err=%b done=%b want 0/0", error_s, done_s); end
      repeat (9) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (18) tick();
      total++; if (state_s !== ST_RUN || cur_step_s !== 2'd1 || busy_s !== 1'b1) begin bad++; $display("FAIL busy_start_ignored: got st=%0d step=%0d busy=%b want %0d/1/1", state_s, cur_step_s, busy_s, ST_RUN); end
      abort = 1'b1;
      tick();
      total++; if (state_s !== ST_DONE || done_s !== 1'b1 || busy_s !== 1'b0) begin bad++; $display("FAIL abort_done: got st=%0d done=%b busy=%b want %0d/1/0", state_s, done_s, busy_s, ST_DONE); end
      total++; if (data_out_s !== 1'b0 || clear_diff_s !== 1'b0 || ps_en_s !== 1'b0) begin bad++; $display("FAIL abort_outputs: got d=%b clr=%b ps=%b want 000", data_out_s, clear_diff_s, ps_en_s); end
      total++; if (pass_count_s !== 3'd1 || error_s !== 1'b0) begin bad++; $display("FAIL abort_results: got pass=%0d err=%b want 1/0", pass_count_s, error_s); end
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      total++; if (state_s !== ST_DONE || busy_s !== 1'b0 || done_c !== 1'b1) begin bad++; $display("FAIL abort_with_start: got st=%0d busy=%b done_c=%b want %0d/0/1", state_s, busy_s, done_c, ST_DONE); end
      repeat (2) tick();
      total++; if (busy_s !== 1'b0 || done_s !== 1'b1) begin bad++; $display("FAIL abort_hold: got busy=%b done=%b want 0/1", busy_s, done_s); end
   endtask

   task automatic test_reset_mid_sweep();
      pulse_start();
      repeat (19) tick();
      total++; if (state_s !== ST_WAIT_PS) begin bad++; $display("FAIL reach_wait_ps: got %0d want %0d", state_s, ST_WAIT_PS); end
      reset = 1'b1;
      tick();
      total++; if ({busy_s, done_s, error_s, fail_found_s, data_out_s, clear_diff_s, ps_en_s} !== 7'b0) begin bad++; $display("FAIL midreset_flags: got %b want 0", {busy_s, done_s, error_s, fail_found_s, data_out_s, clear_diff_s, ps_en_s}); end
      total++; if (pass_count_s !== 3'd0 || cur_step_s !== 2'd0 || state_s !== ST_IDLE) begin bad++; $display("FAIL midreset_state: got pass=%0d step=%0d st=%0d want 0/0/%0d", pass_count_s, cur_step_s, state_s, ST_IDLE); end
      reset = 1'b0;
      repeat (6) tick();
      pulse_start();
      wait_done(200);
      total++; if (dcyc_s !== 86 || pass_count_s !== 3'd4 || nps_s !== 3) begin bad++; $display("FAIL resweep: got lat=%0d pass=%0d ps_en=%0d want 86/4/3", dcyc_s, pass_count_s, nps_s); end
      total++; if (fail_found_s !== 1'b0 || error_s !== 1'b0) begin bad++; $display("FAIL resweep_flags: got ff=%b err=%b want 0/0", fail_found_s, error_s); end
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_fail_stop_and_sweep();
      test_ps_timeout();
      test_abort();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
